// File: rtl/pong_pkg.sv
// Shared types and constants for the match controller: FSM state encoding,
// score width and limits, and the target clamp used when a match starts.
package pong_pkg;

  localparam int SCORE_W    = 6;
  localparam int MAX_TARGET = 20;
  localparam int SCORE_SAT  = 63;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  function automatic logic [SCORE_W-1:0] clamp_target(input logic [SCORE_W-1:0] t);
    if (t == '0)
      return SCORE_W'(1);
    else if (t > SCORE_W'(MAX_TARGET))
      return SCORE_W'(MAX_TARGET);
    else
      return t;
  endfunction

endpackage

// File: rtl/score_match_ctrl_if.sv
// Bundle of match inputs (target, start, goal pulses) and display/ball outputs.
// slave = the controller, master = the surrounding game logic.
interface score_match_ctrl_if;
  import pong_pkg::*;

  logic [SCORE_W-1:0] target;
  logic               start_n;
  logic               goal_l;
  logic               goal_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               ball_en;
  logic               serve_dir;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport slave (
    input  target, start_n, goal_l, goal_r,
    output score_l, score_r, ball_en, serve_dir, game_over, winner, state
  );

  modport master (
    output target, start_n, goal_l, goal_r,
    input  score_l, score_r, ball_en, serve_dir, game_over, winner, state
  );

endinterface

// File: rtl/point_counter.sv
// Per-player score register: synchronous clear, increment, saturates at SCORE_SAT.
module point_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != SCORE_W'(SCORE_SAT)))
      count <= count + SCORE_W'(1);
  end

endmodule

// File: rtl/score_match_ctrl.sv
// Match sequencer for a two-player pong game: serve delay, scoring, win detection.
// Define WIN_BY_TWO_EN to require a two-point lead in addition to reaching the target.
//
//   state | meaning
//   IDLE  | waiting for first start event after reset
//   SERVE | serve delay countdown, goals ignored
//   PLAY  | ball moving, goal pulses scored
//   POINT | one cycle to evaluate the win rule after a score
//   OVER  | match finished, scores frozen until next start
module score_match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_CYCLES = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  score_match_ctrl_if.slave bus
);

  localparam int CNT_W = (SERVE_CYCLES < 2) ? 1 : $clog2(SERVE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] tgt_q, tgt_d;
  logic               start_prev;
  logic               scorer_q, scorer_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               ball_en_q, game_over_q;
  logic               clr, inc_l, inc_r;
  logic               start_ev, win;
  logic [SCORE_W-1:0] score_l, score_r, sc_own, sc_oth;

  assign start_ev = start_prev & ~bus.start_n;

  point_counter u_cnt_l (.clk(clk), .rst(rst), .clr(clr), .inc(inc_l), .count(score_l));
  point_counter u_cnt_r (.clk(clk), .rst(rst), .clr(clr), .inc(inc_r), .count(score_r));

  // Win rule is judged from the scorer's point of view with the already-updated scores.
  always_comb begin
    sc_own = scorer_q ? score_r : score_l;
    sc_oth = scorer_q ? score_l : score_r;
`ifdef WIN_BY_TWO_EN
    win = (sc_own >= tgt_q) &&
          ({1'b0, sc_own} >= ({1'b0, sc_oth} + (SCORE_W+1)'(2)));
`else
    win = (sc_own >= tgt_q);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_q       <= SCORE_W'(1);
      start_prev  <= 1'b1;
      scorer_q    <= 1'b0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      start_prev  <= bus.start_n;
      scorer_q    <= scorer_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_en_q   <= (state_d == PLAY);
      game_over_q <= (state_d == OVER);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start_ev) state_d = SERVE;
      SERVE:      if (cnt_q == '0) state_d = PLAY;
      PLAY: begin
        if (bus.goal_l && bus.goal_r)
          state_d = SERVE;
        else if (bus.goal_l || bus.goal_r)
          state_d = POINT;
      end
      POINT:      state_d = win ? OVER : SERVE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    scorer_d    = scorer_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    clr         = 1'b0;
    inc_l       = 1'b0;
    inc_r       = 1'b0;

    // Down-counter reloads on every entry into SERVE, PLAY follows at terminal count.
    if ((state_d == SERVE) && (state_q != SERVE))
      cnt_d = CNT_LOAD;
    else if ((state_q == SERVE) && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      IDLE, OVER: begin
        if (start_ev) begin
          clr   = 1'b1;
          tgt_d = clamp_target(bus.target);
        end
      end
      PLAY: begin
        if (bus.goal_l ^ bus.goal_r) begin
          inc_l    = bus.goal_l;
          inc_r    = bus.goal_r;
          scorer_d = bus.goal_r;
        end
      end
      POINT: begin
        if (win)
          winner_d = scorer_q;
        else
          serve_dir_d = ~scorer_q;
      end
      default: ;
    endcase
  end

  assign bus.score_l   = score_l;
  assign bus.score_r   = score_r;
  assign bus.ball_en   = ball_en_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.state     = state_q;

endmodule
